// File: rtl/mac_operand_gate.sv
// mac_operand_gate: per-channel operand hold bank for the MAC array; freezes operands after idle_th idle cycles.
// Build option: define ZERO_SKIP_EN to skip loading zero operands and flag those lanes on o_out_zero.
module mac_operand_gate #(
  parameter int bw      = 8,
  parameter int ch      = 4,
  parameter int idle_th = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [ch*bw-1:0]  i_in_data,
  input  logic [ch-1:0]     i_ch_en,
  output logic [ch*bw-1:0]  o_out_data,
  output logic              o_out_valid,
  output logic [ch-1:0]     o_out_zero,
  output logic              o_gated
);

  // state     | meaning
  // ST_ACTIVE | beat accepted last cycle (or just out of reset/wake)
  // ST_IDLE   | counting idle cycles toward gating
  // ST_GATED  | operand registers frozen, not ready
  // ST_WAKE   | one-cycle exit from GATED, not ready
  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_IDLE   = 2'd1,
    ST_GATED  = 2'd2,
    ST_WAKE   = 2'd3
  } state_t;

  localparam int CW = (idle_th > 0) ? $clog2(idle_th + 1) : 1;
  localparam logic [CW-1:0] GATE_AT = (idle_th > 0) ? CW'(idle_th - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_idle_cnt;
  logic [CW-1:0]    w_idle_cnt_nxt;
  logic             w_accept;
  logic [ch*bw-1:0] r_data;
  logic             r_valid;

  assign o_in_ready  = (r_state == ST_ACTIVE) || (r_state == ST_IDLE);
  assign o_gated     = (r_state == ST_GATED);
  assign w_accept    = i_in_valid && o_in_ready;
  assign o_out_data  = r_data;
  assign o_out_valid = r_valid;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= ST_ACTIVE;
      r_idle_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_idle_cnt <= w_idle_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_idle_cnt_nxt = r_idle_cnt;
    case (r_state)
      ST_ACTIVE: begin
        if (w_accept) begin
          w_idle_cnt_nxt = '0;
        end else if (idle_th != 0) begin
          w_state_nxt    = ST_IDLE;
          w_idle_cnt_nxt = CW'(1);
        end
      end
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt    = ST_ACTIVE;
          w_idle_cnt_nxt = '0;
        end else if (r_idle_cnt >= GATE_AT) begin
          // >= keeps idle_th=1 from counting forever
          w_state_nxt = ST_GATED;
        end else if (r_idle_cnt != CNT_MAX) begin
          w_idle_cnt_nxt = CW'(r_idle_cnt + 1'b1);
        end
      end
      ST_GATED: begin
        if (i_in_valid) begin
          w_state_nxt = ST_WAKE;
        end
      end
      ST_WAKE: begin
        w_state_nxt    = ST_ACTIVE;
        w_idle_cnt_nxt = '0;
      end
      default: begin
        w_state_nxt    = ST_ACTIVE;
        w_idle_cnt_nxt = '0;
      end
    endcase
  end

`ifdef ZERO_SKIP_EN
  logic [ch-1:0] r_zero;

  assign o_out_zero = r_zero;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_zero  <= '0;
    end else begin
      r_valid <= w_accept;
      if (w_accept) begin
        for (int k = 0; k < ch; k++) begin
          if (i_ch_en[k]) begin
            if (i_in_data[k*bw +: bw] == '0) begin
              r_zero[k] <= 1'b1;
            end else begin
              r_data[k*bw +: bw] <= i_in_data[k*bw +: bw];
              r_zero[k]          <= 1'b0;
            end
          end
        end
      end
    end
  end
`else
  assign o_out_zero = '0;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_accept;
      if (w_accept) begin
        for (int k = 0; k < ch; k++) begin
          if (i_ch_en[k]) begin
            r_data[k*bw +: bw] <= i_in_data[k*bw +: bw];
          end
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_mac_operand_gate.sv
// Bench for mac_operand_gate: idle_th=4 and idle_th=0 instances against a cycle-level behavioural model.
module tb_mac_operand_gate;
  localparam int BW = 8;
  localparam int CH = 4;
  localparam int W  = BW * CH;
  localparam int TH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 1'b0;
  logic [W-1:0]  i_data = '0;
  logic [CH-1:0] i_en = '0;

  logic          o_ready, o_valid, o_gated;
  logic [W-1:0]  o_data;
  logic [CH-1:0] o_zero;
  logic          z_ready, z_valid, z_gated;
  logic [W-1:0]  z_data;
  logic [CH-1:0] z_zero;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  always #5 clk = ~clk;

  mac_operand_gate #(.bw(BW), .ch(CH), .idle_th(TH)) dut (
    .i_clk(clk), .i_reset(rst), .i_in_valid(i_valid), .o_in_ready(o_ready),
    .i_in_data(i_data), .i_ch_en(i_en), .o_out_data(o_data), .o_out_valid(o_valid),
    .o_out_zero(o_zero), .o_gated(o_gated)
  );

  mac_operand_gate #(.bw(BW), .ch(CH), .idle_th(0)) dut0 (
    .i_clk(clk), .i_reset(rst), .i_in_valid(i_valid), .o_in_ready(z_ready),
    .i_in_data(i_data), .i_ch_en(i_en), .o_out_data(z_data), .o_out_valid(z_valid),
    .o_out_zero(z_zero), .o_gated(z_gated)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Lane-update rule of one accepted beat.
  function automatic void apply(input logic [W-1:0] od, input logic [CH-1:0] oz,
                                input logic [W-1:0] din, input logic [CH-1:0] en,
                                output logic [W-1:0] nd, output logic [CH-1:0] nz);
    nd = od;
    nz = oz;
    for (int k = 0; k < CH; k++) begin
      if (en[k]) begin
`ifdef ZERO_SKIP_EN
        if (din[k*BW +: BW] == '0) nz[k] = 1'b1;
        else begin
          nd[k*BW +: BW] = din[k*BW +: BW];
          nz[k] = 1'b0;
        end
`else
        nd[k*BW +: BW] = din[k*BW +: BW];
`endif
      end
    end
  endfunction

  // phase: 0 = ready (active or counting idle), 1 = gated, 2 = waking
  logic [W-1:0]  m_data, m0_data;
  logic [CH-1:0] m_zero, m0_zero;
  bit            m_ov, m0_ov, m_acc_last;
  int            m_idle, m_phase;

  always @(posedge clk or posedge rst) begin
    logic [W-1:0]  nd;
    logic [CH-1:0] nz;
    bit acc;
    int ni, np;
    if (rst) begin
      m_data <= '0; m_zero <= '0; m_ov <= 0; m_idle <= 0; m_phase <= 0; m_acc_last <= 0;
      m0_data <= '0; m0_zero <= '0; m0_ov <= 0;
    end else begin
      acc = i_valid && (m_phase == 0);
      nd = m_data;
      nz = m_zero;
      if (acc) apply(m_data, m_zero, i_data, i_en, nd, nz);
      ni = m_idle;
      np = m_phase;
      if (m_phase == 0) begin
        if (acc) ni = 0;
        else begin
          ni = m_idle + 1;
          if (TH > 0 && ni >= TH) np = 1;
        end
      end else if (m_phase == 1) begin
        if (i_valid) np = 2;
      end else begin
        np = 0;
        ni = 0;
      end
      m_data <= nd; m_zero <= nz; m_ov <= acc; m_acc_last <= acc;
      m_idle <= ni; m_phase <= np;
      nd = m0_data;
      nz = m0_zero;
      if (i_valid) apply(m0_data, m0_zero, i_data, i_en, nd, nz);
      m0_data <= nd; m0_zero <= nz; m0_ov <= i_valid;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", o_ready, m_phase == 0);
      chk("gated", o_gated, m_phase == 1);
      chk("out_valid", o_valid, m_ov);
      chk("out_data", o_data, m_data);
      chk("out_zero", o_zero, m_zero);
      chk("th0_ready", z_ready, 1'b1);
      chk("th0_gated", z_gated, 1'b0);
      chk("th0_valid", z_valid, m0_ov);
      chk("th0_data", z_data, m0_data);
      chk("th0_zero", z_zero, m0_zero);
    end
  end

  task automatic step(input bit v, input logic [W-1:0] d, input logic [CH-1:0] e);
    @(posedge clk);
    #1;
    i_valid = v;
    i_data  = d;
    i_en    = e;
  endtask

  initial begin
    int lat;
    int rate;
    logic [W-1:0] d;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1;

    // reset in the middle of an offered beat
    step(1, 32'hA5A5A5A5, 4'hF);
    step(1, 32'h5A5A5A5A, 4'hF);
    chk("pre_reset_data", o_data, 32'hA5A5A5A5);
    #2 rst = 1'b1;
    #1;
    chk("rst_data", o_data, 32'h0);
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_gated", o_gated, 1'b0);
    i_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", o_ready, 1'b1);
    chk("post_rst_data", o_data, 32'h0);

    // full-width signed extremes, one-cycle pulse
    step(1, 32'h7F8001FF, 4'hF);
    step(0, '0, '0);
    @(negedge clk);
    chk("beat_data", o_data, 32'h7F8001FF);
    chk("beat_valid", o_valid, 1'b1);
    @(negedge clk);
    chk("beat_valid_drop", o_valid, 1'b0);

`ifdef ZERO_SKIP_EN
    step(1, 32'h00000005, 4'b0001);
    step(1, 32'h00000000, 4'b0001);
    step(0, '0, '0);
    @(negedge clk);
    chk("zs_hold", o_data[7:0], 8'h05);
    chk("zs_flag", o_zero[0], 1'b1);
    step(1, 32'h00000003, 4'b0001);
    step(0, '0, '0);
    @(negedge clk);
    chk("zs_load", o_data[7:0], 8'h03);
    chk("zs_clear", o_zero[0], 1'b0);
`endif

    // channel mask
    step(1, 32'h22222222, 4'hF);
    step(1, 32'h11111111, 4'b0101);
    step(0, '0, '0);
    @(negedge clk);
    chk("mask_data", o_data, 32'h22112211);

    // idle to gated, then wake with a held beat
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("idle_gate", o_gated, (i == 4));
    end
    i_valid = 1'b1;
    i_data  = 32'hC3C3C3C3;
    i_en    = 4'hF;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) chk("wake_ready", o_ready, 1'b0);
      if (o_valid) begin
        lat = k;
        break;
      end
    end
    i_valid = 1'b0;
    chk("wake_latency", lat, 3);
    chk("wake_data", o_data, 32'hC3C3C3C3);

    // randomized traffic with varying load; unaccepted beats are held
    rate = 90;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      if (c % 200 == 0) rate = (c / 200 % 3 == 0) ? 90 : (c / 200 % 3 == 1) ? 50 : 8;
      if (!(i_valid && !m_acc_last)) begin
        i_valid = ($urandom_range(0, 99) < rate);
        d = $urandom;
        for (int k = 0; k < CH; k++)
          if ($urandom_range(0, 3) == 0) d[k*BW +: BW] = '0;
        i_data = d;
        i_en   = 4'($urandom);
      end
    end

    // long idle: idle_th=0 never gates, idle_th=4 does
    @(posedge clk);
    #1 i_valid = 1'b0;
    repeat (100) begin
      @(negedge clk);
      chk("th0_long_idle", z_gated, 1'b0);
    end
    chk("th4_long_idle", o_gated, 1'b1);

    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
